// File: rtl/core_ldst_mult_seq_pkg.sv
// Shared types for the LDM/STM block-transfer sequencer.
package core_ldst_mult_seq_pkg;
  typedef logic [3:0]  reg_num;
  typedef logic [31:0] word;
  typedef logic [1:0]  ldst_mult_state;

  localparam ldst_mult_state ST_IDLE = 2'd0;
  localparam ldst_mult_state ST_XFER = 2'd1;
  localparam ldst_mult_state ST_FIN  = 2'd2;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction
endpackage

// File: rtl/core_ldst_mult_seq_pe.sv
// Lowest-set-bit priority encoder over a 16-bit register list.
module core_ldst_mult_pe
  import core_ldst_mult_seq_pkg::*;
(
  input  logic [15:0] vec,
  output reg_num      idx,
  output logic        valid
);
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Descending scan so the lowest set bit is the last one written.
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = reg_num'(i);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/core_ldst_mult_seq.sv
// LDM/STM sequencer: one word transfer per listed register, then base writeback.
module core_ldst_mult_seq
  import core_ldst_mult_seq_pkg::*;
#(
  parameter int FAULT_WB = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] list,
  input  logic        up,
  input  logic        pre,
  input  logic        load,
  input  logic        writeback,
  input  logic [3:0]  base_reg,
  input  logic [31:0] base,
  output logic        ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  input  logic        mem_ready,
  input  logic        mem_fault,
  output logic [3:0]  xfer_reg,
  output logic        load_wr,
  output logic        base_wr,
  output logic [31:0] base_wr_value,
  output logic        done,
  output logic        fault,
  output logic        pc_loaded
);
  ldst_mult_state state_q, state_d;
  logic [15:0] rem_q, rem_d, list_q, list_d;
  word         addr_q, addr_d, final_q, final_d;
  logic        load_q, load_d, wb_q, wb_d, fault_q, fault_d, pc_q, pc_d;
  reg_num      base_reg_q, base_reg_d;

  reg_num pe_idx;
  logic   pe_vld;
  core_ldst_mult_pe u_pe (.vec(rem_q), .idx(pe_idx), .valid(pe_vld));

  word        base_al, offs;
  logic [4:0] n;
  assign base_al = base & ~32'h3;
  assign n       = popcount16(list);
  assign offs    = {25'd0, n, 2'b00};

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    list_d     = list_q;
    addr_d     = addr_q;
    final_d    = final_q;
    load_d     = load_q;
    wb_d       = wb_q;
    base_reg_d = base_reg_q;
    fault_d    = fault_q;
    pc_d       = pc_q;
    case (state_q)
      ST_IDLE: if (start) begin
        rem_d      = list;
        list_d     = list;
        load_d     = load;
        wb_d       = writeback;
        base_reg_d = base_reg;
        fault_d    = 1'b0;
        pc_d       = 1'b0;
        case ({up, pre})
          2'b10:   addr_d = base_al;
          2'b11:   addr_d = base_al + 32'd4;
          2'b00:   addr_d = base_al - offs + 32'd4;
          default: addr_d = base_al - offs;
        endcase
        final_d = up ? base_al + offs : base_al - offs;
        state_d = (n != 5'd0) ? ST_XFER : ST_FIN;
      end
      ST_XFER: if (mem_ready) begin
        if (mem_fault) begin
          fault_d = 1'b1;
          rem_d   = '0;
          state_d = ST_FIN;
        end else begin
          // Clear the lowest set bit: the register just transferred.
          rem_d  = rem_q & (rem_q - 16'd1);
          addr_d = addr_q + 32'd4;
          if (load_q && pe_idx == 4'd15) pc_d = 1'b1;
          if (rem_d == 16'd0) state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      list_q     <= '0;
      addr_q     <= '0;
      final_q    <= '0;
      load_q     <= 1'b0;
      wb_q       <= 1'b0;
      base_reg_q <= '0;
      fault_q    <= 1'b0;
      pc_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      list_q     <= list_d;
      addr_q     <= addr_d;
      final_q    <= final_d;
      load_q     <= load_d;
      wb_q       <= wb_d;
      base_reg_q <= base_reg_d;
      fault_q    <= fault_d;
      pc_q       <= pc_d;
    end
  end

  logic in_xfer, in_fin;
  assign in_xfer = (state_q == ST_XFER) & pe_vld;
  assign in_fin  = (state_q == ST_FIN);

  assign ready     = (state_q == ST_IDLE);
  assign mem_req   = in_xfer;
  assign mem_addr  = in_xfer ? addr_q : '0;
  assign mem_write = in_xfer & ~load_q;
  assign xfer_reg  = in_xfer ? pe_idx : '0;
  assign load_wr   = in_xfer & mem_ready & load_q & ~mem_fault;

  // A base register that was itself loaded wins over writeback.
  assign base_wr = in_fin & wb_q & ~(load_q & list_q[base_reg_q])
                 & (~fault_q | (FAULT_WB != 0));
  assign base_wr_value = in_fin ? final_q : '0;
  assign done      = in_fin;
  assign fault     = in_fin & fault_q;
  assign pc_loaded = in_fin & pc_q;
endmodule

// File: tb/tb_core_ldst_mult_seq.sv
// Directed bench for the LDM/STM sequencer.
module tb_core_ldst_mult_seq;
  logic        clk = 1'b0;
  logic        rst, start, up, pre, load, writeback, mem_ready, mem_fault;
  logic [15:0] list;
  logic [3:0]  base_reg;
  logic [31:0] base;
  logic        ready, mem_req, mem_write, load_wr, base_wr, done, fault, pc_loaded;
  logic [31:0] mem_addr, base_wr_value;
  logic [3:0]  xfer_reg;
  int tests = 0, failed = 0;

  core_ldst_mult_seq #(.FAULT_WB(0)) dut (
    .clk(clk), .rst(rst), .start(start), .list(list), .up(up), .pre(pre),
    .load(load), .writeback(writeback), .base_reg(base_reg), .base(base),
    .ready(ready), .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_ready(mem_ready), .mem_fault(mem_fault), .xfer_reg(xfer_reg),
    .load_wr(load_wr), .base_wr(base_wr), .base_wr_value(base_wr_value),
    .done(done), .fault(fault), .pc_loaded(pc_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %h expected %h", t, obs, exp);
    end
  endtask

  task automatic chkb(input string t, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %b expected %b", t, obs, exp);
    end
  endtask

  task automatic idle(input string t);
    #1;
    chkb({t, " ready"}, ready, 1'b1);
    chkb({t, " mem_req"}, mem_req, 1'b0);
    chk ({t, " mem_addr"}, mem_addr, 32'h0);
    chkb({t, " mem_write"}, mem_write, 1'b0);
    chk ({t, " xfer_reg"}, 32'(xfer_reg), 32'h0);
    chkb({t, " load_wr"}, load_wr, 1'b0);
    chkb({t, " base_wr"}, base_wr, 1'b0);
    chk ({t, " base_wr_value"}, base_wr_value, 32'h0);
    chkb({t, " done"}, done, 1'b0);
    chkb({t, " fault"}, fault, 1'b0);
    chkb({t, " pc_loaded"}, pc_loaded, 1'b0);
  endtask

  task automatic issue(input logic [15:0] l, input logic u, input logic p, input logic ld,
                       input logic w, input logic [3:0] br, input logic [31:0] b);
    list = l; up = u; pre = p; load = ld; writeback = w; base_reg = br; base = b;
    start = 1'b1;
    #1;
    chkb("issue ready", ready, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic xchk(input string t, input logic [31:0] a, input logic [3:0] r,
                      input logic w, input logic lw);
    #1;
    chkb({t, " mem_req"}, mem_req, 1'b1);
    chk ({t, " mem_addr"}, mem_addr, a);
    chk ({t, " xfer_reg"}, 32'(xfer_reg), 32'(r));
    chkb({t, " mem_write"}, mem_write, w);
    chkb({t, " load_wr"}, load_wr, lw);
    chkb({t, " done"}, done, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic fchk(input string t, input logic f, input logic pc, input logic bw,
                      input logic [31:0] bwv);
    #1;
    chkb({t, " done"}, done, 1'b1);
    chkb({t, " fault"}, fault, f);
    chkb({t, " pc_loaded"}, pc_loaded, pc);
    chkb({t, " base_wr"}, base_wr, bw);
    chk ({t, " base_wr_value"}, base_wr_value, bwv);
    chkb({t, " mem_req"}, mem_req, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; list = '0; up = 1'b0; pre = 1'b0; load = 1'b0;
    writeback = 1'b0; base_reg = '0; base = '0; mem_ready = 1'b0; mem_fault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // STMIA r0,r1,r4 from 0x1000 with writeback
    mem_ready = 1'b1;
    issue(16'h0013, 1'b1, 1'b0, 1'b0, 1'b1, 4'd13, 32'h0000_1000);
    xchk("stmia x0", 32'h0000_1000, 4'd0, 1'b1, 1'b0);
    xchk("stmia x1", 32'h0000_1004, 4'd1, 1'b1, 1'b0);
    xchk("stmia x2", 32'h0000_1008, 4'd4, 1'b1, 1'b0);
    fchk("stmia fin", 1'b0, 1'b0, 1'b1, 32'h0000_100C);

    // LDMDB r0,r1,pc from 0x2000, issued back-to-back
    issue(16'h8003, 1'b0, 1'b1, 1'b1, 1'b1, 4'd13, 32'h0000_2000);
    xchk("ldmdb x0", 32'h0000_1FF4, 4'd0, 1'b0, 1'b1);
    xchk("ldmdb x1", 32'h0000_1FF8, 4'd1, 1'b0, 1'b1);
    xchk("ldmdb x2", 32'h0000_1FFC, 4'd15, 1'b0, 1'b1);
    fchk("ldmdb fin", 1'b0, 1'b1, 1'b1, 32'h0000_1FF4);

    // LDMIA loading the base itself: writeback suppressed
    issue(16'h0004, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'h0000_3000);
    xchk("ldmia_b x0", 32'h0000_3000, 4'd2, 1'b0, 1'b1);
    fchk("ldmia_b fin", 1'b0, 1'b0, 1'b0, 32'h0000_3004);

    // STMIB with three wait cycles on the first beat
    mem_ready = 1'b0;
    issue(16'h0003, 1'b1, 1'b1, 1'b0, 1'b0, 4'd13, 32'h0000_4000);
    xchk("stmib w0", 32'h0000_4004, 4'd0, 1'b1, 1'b0);
    xchk("stmib w1", 32'h0000_4004, 4'd0, 1'b1, 1'b0);
    xchk("stmib w2", 32'h0000_4004, 4'd0, 1'b1, 1'b0);
    mem_ready = 1'b1;
    xchk("stmib x0", 32'h0000_4004, 4'd0, 1'b1, 1'b0);
    xchk("stmib x1", 32'h0000_4008, 4'd1, 1'b1, 1'b0);
    fchk("stmib fin", 1'b0, 1'b0, 1'b0, 32'h0000_4008);

    // LDMIA with a fault on the second beat; a stray start is ignored
    issue(16'h000F, 1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 32'h0000_5000);
    xchk("fault x0", 32'h0000_5000, 4'd0, 1'b0, 1'b1);
    mem_fault = 1'b1; start = 1'b1; list = 16'hFFFF;
    xchk("fault x1", 32'h0000_5004, 4'd1, 1'b0, 1'b0);
    mem_fault = 1'b0; start = 1'b0;
    fchk("fault fin", 1'b1, 1'b0, 1'b0, 32'h0000_5010);
    idle("fault after");
    @(posedge clk); #1;

    // Empty list, unaligned base bits dropped
    issue(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'd13, 32'h0000_6003);
    fchk("empty fin", 1'b0, 1'b0, 1'b1, 32'h0000_6000);

    // Address wrap past the top of memory
    issue(16'h0003, 1'b1, 1'b0, 1'b0, 1'b1, 4'd13, 32'hFFFF_FFFC);
    xchk("wrap x0", 32'hFFFF_FFFC, 4'd0, 1'b1, 1'b0);
    xchk("wrap x1", 32'h0000_0000, 4'd1, 1'b1, 1'b0);
    fchk("wrap fin", 1'b0, 1'b0, 1'b1, 32'h0000_0004);

    // Reset in the middle of a transfer
    mem_ready = 1'b0;
    issue(16'h00FF, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 32'h0000_7000);
    xchk("rstmid x0", 32'h0000_7000, 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    idle("rstmid asserted");
    @(posedge clk); #1;
    rst = 1'b0;
    idle("rstmid released");
    @(posedge clk); #1;
    idle("rstmid after");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
